board_ram_scheduler: RTL and testbench
======================================

Name: board_ram_scheduler

Overview:
Owns the single-port 32768x3 board RAM and sequences every access to it. On each game tick it performs the per-player read/check/write pass, which claims turf, detects collisions and kills players. It also runs a full-board clear on request. Between passes it grants the shared RAM port to the display reader, and it holds the authoritative player-alive state.

Parameters:
ADDR_W, 15, RAM address width; address = {x[7:0], y[6:0]}
X_MAX, 160, first illegal x value; x >= X_MAX is out of bounds
Y_MAX, 120, first illegal y value; y >= Y_MAX is out of bounds
CLEAR_WORDS, 32768, number of addresses swept by a clear (0..CLEAR_WORDS-1); reduced in simulation

Ports:
CLOCK_50  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle game-step pulse from the rate divider
clear_req  in  1  level; request a board clear plus revive of all players
pos1, pos2, pos3, pos4  in  15 each  player head position {x, y}; must be stable for the cycle in which tick is accepted
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_data  out  3  RAM write data
ram_q  in  3  RAM read data; valid the cycle after the address is presented
disp_req  in  1  display read request
disp_addr  in  ADDR_W  display read address
disp_grant  out  1  display request accepted this cycle
disp_valid  out  1  disp_data valid; asserted one cycle after disp_grant
disp_data  out  3  display read data
alive  out  4  alive[i-1] = player i alive
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at the end of an update pass
overrun  out  1  sticky; set when a tick is dropped

Behaviour:
- Reset values: state IDLE; ram_wren=0; ram_addr=0; ram_data=0; disp_grant=0; disp_valid=0; disp_data=0; alive=4'b1111; busy=0; done=0; overrun=0; pending=0.
- Reset taking effect mid-pass or mid-clear aborts the operation immediately. RAM contents are left as they are.
- States are IDLE, CLEAR, RD1, WR1, RD2, WR2, RD3, WR3, RD4, WR4, DONE.
- IDLE priority order:
  - clear_req goes to CLEAR, with the clear counter set to 0.
  - Otherwise, tick or pending goes to RD1. pos1..pos4 and the alive mask are snapshotted on that edge, and pending is cleared.
  - Otherwise, disp_req is served.
- Display service: disp_grant=1 in the same cycle as disp_req, driven combinationally; ram_addr=disp_addr and wren=0. On the next cycle, disp_valid=1 and disp_data=ram_q. disp_grant=0 in every state other than IDLE.
- CLEAR: each cycle wren=1, data=3'b000, addr=counter, then counter+1. After address CLEAR_WORDS-1 is written, alive<=4'b1111 and the block returns to IDLE; no done pulse. Ticks arriving during CLEAR are discarded and do not set overrun.
- RDi: addr=snap_pos_i, wren=0.
- WRi: ram_q holds the cell value. If player i is dead in the snapshot, then wren=0 and there is no change. Otherwise player i dies when any of these holds:
  - x >= X_MAX or y >= Y_MAX; in this case wren=0.
  - ram_q != 0; in this case wren=1 at the same address with data=3'b111.
  - snap_pos_i equals the snapshot position of any other player alive in the snapshot (head-on); in this case wren=1 with data=3'b111.
- If none of the death conditions holds, wren=1 with data set to the player colour: p1=001, p2=010, p3=100, p4=110.
- Deaths clear alive[i] at the end of WRi. The collision check uses the snapshot alive mask, so two heads on the same cell both die.
- Latency: tick accepted at edge E0. Then RD1..WR4 occupy cycles 1..8, DONE occupies cycle 9 with done=1, and the block is back in IDLE at cycle 10. The pass length is fixed regardless of how many players are alive.
- A tick seen in any state from RD1 to DONE sets pending. If pending is already set, the tick is dropped and overrun is set; overrun is cleared only by reset.
- clear_req asserted during a pass takes effect only after DONE.
- alive changes only in WRi (deaths) and at the end of CLEAR (revive).

Test Plan:
- Reset then tick, board clear, pos1=0x4F77, pos2=0x0001, pos3=0x4F01, pos4=0x0077 -> writes of 001/010/100/110 at those addresses in cycles 2/4/6/8; done in cycle 9; alive=1111.
- Preload RAM[0x0001]=3'b001, tick with pos2=0x0001 -> WR2 writes 111; alive=1101; pass length still 10 cycles.
- pos1=pos3=0x2A2A, cell empty, tick -> both write 111; alive=1010. Next tick -> players 1 and 3 get no wren.
- pos4 x=160 (0x5000), tick -> no write for player 4; alive[3]=0.
- disp_req held with addr 0x0005 while a tick arrives -> grant=0 for cycles 1-9; grant resumes at cycle 10; disp_valid follows one cycle after each grant. Three ticks during one pass -> one extra pass runs and overrun=1.
- CLEAR_WORDS=64, clear_req -> 64 consecutive writes of 000 at addresses 0..63, busy high for 64 cycles, alive=1111. Reset asserted mid-clear at address 20 -> wren=0 and IDLE immediately.

Source files
------------

// File: rtl/board_ram_scheduler_if.sv
// Board RAM scheduler bus bundle.
// Groups the game-control inputs, the single-port RAM connection, the
// display read port and the status outputs of board_ram_scheduler.
//   master : the scheduler side (drives RAM address/controls, grants, status)
//   slave  : the environment side (game logic, RAM, display reader)
interface board_ram_scheduler_if #(
   parameter int ADDR_W = 15
);
   logic              tick;
   logic              clear_req;
   logic [ADDR_W-1:0] pos1;
   logic [ADDR_W-1:0] pos2;
   logic [ADDR_W-1:0] pos3;
   logic [ADDR_W-1:0] pos4;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [2:0]        ram_data;
   logic [2:0]        ram_q;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_grant;
   logic              disp_valid;
   logic [2:0]        disp_data;
   logic [3:0]        alive;
   logic              busy;
   logic              done;
   logic              overrun;

   modport master (
      input  tick, clear_req, pos1, pos2, pos3, pos4, ram_q, disp_req, disp_addr,
      output ram_addr, ram_wren, ram_data, disp_grant, disp_valid, disp_data,
             alive, busy, done, overrun
   );

   modport slave (
      output tick, clear_req, pos1, pos2, pos3, pos4, ram_q, disp_req, disp_addr,
      input  ram_addr, ram_wren, ram_data, disp_grant, disp_valid, disp_data,
             alive, busy, done, overrun
   );
endinterface

// File: rtl/board_ram_scheduler.sv
// Board RAM scheduler: sole owner of the single-port 3-bit board RAM.
// Runs the per-tick read/check/write pass over the four players (turf
// claiming, collision and out-of-bounds deaths), the full-board clear, and
// lends the RAM port to the display reader while idle. Holds player alive state.
// Ports:
//   CLOCK_50 : system clock, posedge
//   reset    : asynchronous active-high reset
//   bus      : board_ram_scheduler_if.master (game inputs, RAM port,
//              display port, alive/busy/done/overrun status)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting; serves display reads, launches clear or pass
// CLEAR   | writes 000 to one address per cycle, revives all players at end
// RDi     | presents player i snapshot position to the RAM
// WRi     | checks cell value / bounds / head-on, writes colour or 111
// DONE    | one-cycle done pulse closing the pass
module board_ram_scheduler #(
   parameter int ADDR_W      = 15,
   parameter int X_MAX       = 160,
   parameter int Y_MAX       = 120,
   parameter int CLEAR_WORDS = 32768
) (
   input logic                   CLOCK_50,
   input logic                   reset,
   board_ram_scheduler_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_RD1, S_WR1, S_RD2, S_WR2,
      S_RD3, S_WR3, S_RD4, S_WR4, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      clr_cnt_q, clr_cnt_d;
   logic [3:0][ADDR_W-1:0] snap_pos_q, snap_pos_d;
   logic [3:0]             snap_alive_q, snap_alive_d;
   logic [3:0]             alive_q, alive_d;
   logic                   pending_q, pending_d;
   logic                   overrun_q, overrun_d;
   logic                   disp_valid_q;

   logic [ADDR_W-1:0] addr_c;
   logic              wren_c;
   logic [2:0]        data_c;
   logic              grant_c;
   logic [1:0]        p;
   logic              rd_st, wr_st, in_pass;
   logic [ADDR_W-1:0] cur_pos;
   logic              oob, head_on;

   function automatic logic [2:0] colour(input logic [1:0] idx);
      case (idx)
         2'd0:    colour = 3'b001;
         2'd1:    colour = 3'b010;
         2'd2:    colour = 3'b100;
         default: colour = 3'b110;
      endcase
   endfunction

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         clr_cnt_q    <= '0;
         snap_pos_q   <= '0;
         snap_alive_q <= '0;
         alive_q      <= 4'b1111;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         snap_pos_q   <= snap_pos_d;
         snap_alive_q <= snap_alive_d;
         alive_q      <= alive_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         disp_valid_q <= grant_c;
      end
   end

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      snap_pos_d   = snap_pos_q;
      snap_alive_d = snap_alive_q;
      alive_d      = alive_q;
      pending_d    = pending_q;
      overrun_d    = overrun_q;
      addr_c       = '0;
      wren_c       = 1'b0;
      data_c       = 3'b000;
      grant_c      = 1'b0;
      p            = 2'd0;
      rd_st        = 1'b0;
      wr_st        = 1'b0;
      in_pass      = 1'b0;
      head_on      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.clear_req) begin
               state_d   = S_CLEAR;
               clr_cnt_d = '0;
            end else if (bus.tick || pending_q) begin
               state_d       = S_RD1;
               snap_pos_d[0] = bus.pos1;
               snap_pos_d[1] = bus.pos2;
               snap_pos_d[2] = bus.pos3;
               snap_pos_d[3] = bus.pos4;
               snap_alive_d  = alive_q;
               pending_d     = 1'b0;
            end else if (bus.disp_req && !reset) begin
               grant_c = 1'b1;
               addr_c  = bus.disp_addr;
            end
         end
         S_CLEAR: begin
            wren_c    = 1'b1;
            addr_c    = clr_cnt_q;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
               alive_d = 4'b1111;
               state_d = S_IDLE;
            end
         end
         S_RD1: begin p = 2'd0; rd_st = 1'b1; state_d = S_WR1; end
         S_WR1: begin p = 2'd0; wr_st = 1'b1; state_d = S_RD2; end
         S_RD2: begin p = 2'd1; rd_st = 1'b1; state_d = S_WR2; end
         S_WR2: begin p = 2'd1; wr_st = 1'b1; state_d = S_RD3; end
         S_RD3: begin p = 2'd2; rd_st = 1'b1; state_d = S_WR3; end
         S_WR3: begin p = 2'd2; wr_st = 1'b1; state_d = S_RD4; end
         S_RD4: begin p = 2'd3; rd_st = 1'b1; state_d = S_WR4; end
         S_WR4: begin p = 2'd3; wr_st = 1'b1; state_d = S_DONE; end
         S_DONE: begin in_pass = 1'b1; state_d = S_IDLE; end
         default: state_d = S_IDLE;
      endcase

      // One tick may queue behind a running pass; a second one is lost.
      in_pass = in_pass | rd_st | wr_st;
      if (in_pass && bus.tick) begin
         if (pending_q) overrun_d = 1'b1;
         else           pending_d = 1'b1;
      end

      cur_pos = snap_pos_q[p];
      oob     = (int'(cur_pos[ADDR_W-1:7]) >= X_MAX) || (int'(cur_pos[6:0]) >= Y_MAX);
      // Snapshot alive mask, so two heads on one cell both see each other.
      for (int j = 0; j < 4; j++) begin
         if (2'(j) != p && snap_alive_q[j] && snap_pos_q[j] == cur_pos) head_on = 1'b1;
      end

      if (rd_st || wr_st) addr_c = cur_pos;
      if (wr_st && snap_alive_q[p]) begin
         if (oob) begin
            alive_d[p] = 1'b0;
         end else if (bus.ram_q != 3'b000 || head_on) begin
            wren_c     = 1'b1;
            data_c     = 3'b111;
            alive_d[p] = 1'b0;
         end else begin
            wren_c = 1'b1;
            data_c = colour(p);
         end
      end
   end

   assign bus.ram_addr   = addr_c;
   assign bus.ram_wren   = wren_c;
   assign bus.ram_data   = data_c;
   assign bus.disp_grant = grant_c;
   assign bus.disp_valid = disp_valid_q;
   assign bus.disp_data  = disp_valid_q ? bus.ram_q : 3'b000;
   assign bus.alive      = alive_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_board_ram_scheduler.sv
// Bench for board_ram_scheduler: RAM model, write/display scoreboards and
// directed game scenarios with hand-computed expected values.
module tb_board_ram_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   board_ram_scheduler_if #(.ADDR_W(15)) bus ();

   board_ram_scheduler #(.CLEAR_WORDS(64)) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   logic [2:0]  mem [0:32767] = '{default: 3'b000};
   logic        pre_en   = 1'b0;
   logic [14:0] pre_addr = '0;
   logic [2:0]  pre_data = '0;

   always @(posedge clk) begin
      if (pre_en)            mem[pre_addr] <= pre_data;
      else if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
      bus.ram_q <= mem[bus.ram_addr];
   end

   logic [17:0] wq [$];
   logic [2:0]  dq [$];
   logic [17:0] we;
   logic [2:0]  de;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void push_wr(input logic [14:0] a, input logic [2:0] d);
      wq.push_back({a, d});
   endfunction

   // Scoreboard monitor: every RAM write and every display data beat is
   // matched against the oldest expectation queued by the stimulus.
   always @(negedge clk) begin
      if (bus.ram_wren === 1'b1) begin
         if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected: got addr=%h data=%b expected none", bus.ram_addr, bus.ram_data);
         end else begin
            we = wq.pop_front();
            chk("wr", {14'd0, bus.ram_addr, bus.ram_data}, {14'd0, we});
         end
      end
      if (bus.disp_valid === 1'b1) begin
         if (dq.size() == 0) begin
            total++; bad++;
            $display("FAIL disp_unexpected: got data=%b expected none", bus.disp_data);
         end else begin
            de = dq.pop_front();
            chk("disp_data", 32'(bus.disp_data), 32'(de));
         end
      end
   end

   task automatic preload(input logic [14:0] a, input logic [2:0] d);
      @(posedge clk); #1 pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1 pre_en = 1'b0;
   endtask

   task automatic set_pos(input logic [14:0] a, b, c, d);
      bus.pos1 = a; bus.pos2 = b; bus.pos3 = c; bus.pos4 = d;
   endtask

   task automatic do_tick();
      @(posedge clk); #1 bus.tick = 1'b1;
      @(posedge clk); #1 bus.tick = 1'b0;
   endtask

   // Cycle n = n-th cycle after the edge accepting the tick.
   task automatic run_pass(input string nm, input logic [12:0] exp_wm, input logic [3:0] exp_alive);
      logic [12:0] wm;
      int          dc;
      wm = '0;
      dc = 0;
      do_tick();
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (bus.ram_wren) wm[n] = 1'b1;
         if (bus.done && dc == 0) dc = n;
         if (n == 10) chk({nm, "_busy_c10"}, 32'(bus.busy), 32'd0);
         @(posedge clk); #1;
      end
      chk({nm, "_done_cycle"}, 32'(dc), 32'd9);
      chk({nm, "_wr_cycles"}, 32'(wm), 32'(exp_wm));
      chk({nm, "_alive"}, 32'(bus.alive), 32'(exp_alive));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cnt, dn;
      logic [22:0] dmask;
      bus.tick = 1'b0; bus.clear_req = 1'b0; bus.disp_req = 1'b0; bus.disp_addr = '0;
      set_pos(15'h0, 15'h0, 15'h0, 15'h0);

      // reset state
      @(negedge clk);
      chk("rst_wren", 32'(bus.ram_wren), 0);
      chk("rst_addr", 32'(bus.ram_addr), 0);
      chk("rst_data", 32'(bus.ram_data), 0);
      chk("rst_grant", 32'(bus.disp_grant), 0);
      chk("rst_valid", 32'(bus.disp_valid), 0);
      chk("rst_ddata", 32'(bus.disp_data), 0);
      chk("rst_alive", 32'(bus.alive), 32'hF);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_overrun", 32'(bus.overrun), 0);
      @(posedge clk); #1 rst = 1'b0;

      // four players on empty cells at the board corners
      set_pos(15'h4F77, 15'h0001, 15'h4F01, 15'h0077);
      push_wr(15'h4F77, 3'b001); push_wr(15'h0001, 3'b010);
      push_wr(15'h4F01, 3'b100); push_wr(15'h0077, 3'b110);
      run_pass("p_basic", 13'h154, 4'b1111);

      // player 2 runs into occupied turf
      preload(15'h0001, 3'b001);
      set_pos(15'h0102, 15'h0001, 15'h0203, 15'h0304);
      push_wr(15'h0102, 3'b001); push_wr(15'h0001, 3'b111);
      push_wr(15'h0203, 3'b100); push_wr(15'h0304, 3'b110);
      run_pass("p_occupied", 13'h154, 4'b1101);

      // head-on: players 1 and 3 share a cell
      set_pos(15'h2A2A, 15'h0001, 15'h2A2A, 15'h0405);
      push_wr(15'h2A2A, 3'b111); push_wr(15'h2A2A, 3'b111); push_wr(15'h0405, 3'b110);
      run_pass("p_headon", 13'h144, 4'b1000);

      // dead players stay silent
      set_pos(15'h0506, 15'h0001, 15'h0607, 15'h0708);
      push_wr(15'h0708, 3'b110);
      run_pass("p_dead", 13'h100, 4'b1000);

      // x = 160 is off the board
      set_pos(15'h0506, 15'h0001, 15'h0607, 15'h5000);
      run_pass("p_oob", 13'h000, 4'b0000);

      // full clear with a stray tick inside it
      @(posedge clk); #1 bus.clear_req = 1'b1;
      for (int i = 0; i < 64; i++) push_wr(15'(i), 3'b000);
      @(posedge clk); #1 bus.clear_req = 1'b0;
      cnt = 0; dn = 0;
      for (int n = 0; n < 200; n++) begin
         bus.tick = (n == 5);
         @(negedge clk);
         if (!bus.busy) break;
         cnt++;
         if (bus.done) dn++;
         @(posedge clk); #1;
      end
      bus.tick = 1'b0;
      chk("clr_busy_cycles", 32'(cnt), 32'd64);
      chk("clr_done_pulses", 32'(dn), 32'd0);
      chk("clr_alive", 32'(bus.alive), 32'hF);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("clr_tick_dropped", 32'(bus.busy), 0);
      chk("clr_overrun", 32'(bus.overrun), 0);
      @(posedge clk); #1;

      // display reader held across a pass
      preload(15'h0005, 3'b101);
      set_pos(15'h0A01, 15'h0A02, 15'h0A03, 15'h0A04);
      push_wr(15'h0A01, 3'b001); push_wr(15'h0A02, 3'b010);
      push_wr(15'h0A03, 3'b100); push_wr(15'h0A04, 3'b110);
      bus.disp_addr = 15'h0005; bus.disp_req = 1'b1; dq.push_back(3'b101);
      @(negedge clk);
      chk("disp_grant_idle", 32'(bus.disp_grant), 1);
      @(posedge clk); #1 bus.tick = 1'b1;
      @(posedge clk); #1 bus.tick = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         if (n == 10) dq.push_back(3'b101);
         @(negedge clk);
         chk($sformatf("disp_grant_c%0d", n), 32'(bus.disp_grant), 32'(n == 10));
         if (n == 9) chk("disp_done_c9", 32'(bus.done), 1);
         @(posedge clk); #1;
      end
      bus.disp_req = 1'b0;
      @(negedge clk);
      chk("disp_alive", 32'(bus.alive), 32'hF);
      @(posedge clk); #1;

      // three ticks during one pass: one extra pass, overrun set
      set_pos(15'h0B01, 15'h0B02, 15'h0B03, 15'h0B04);
      push_wr(15'h0B01, 3'b001); push_wr(15'h0B02, 3'b010);
      push_wr(15'h0B03, 3'b100); push_wr(15'h0B04, 3'b110);
      push_wr(15'h0B01, 3'b111); push_wr(15'h0B02, 3'b111);
      push_wr(15'h0B03, 3'b111); push_wr(15'h0B04, 3'b111);
      dmask = '0;
      do_tick();
      for (int n = 1; n <= 22; n++) begin
         bus.tick = (n == 2 || n == 4 || n == 6);
         @(negedge clk);
         if (bus.done) dmask[n] = 1'b1;
         if (n == 3) chk("ovr_c3", 32'(bus.overrun), 0);
         if (n == 5) chk("ovr_c5", 32'(bus.overrun), 1);
         @(posedge clk); #1;
      end
      bus.tick = 1'b0;
      chk("ovr_done_cycles", 32'(dmask), 32'h80200);
      chk("ovr_alive", 32'(bus.alive), 0);
      chk("ovr_sticky", 32'(bus.overrun), 1);

      // reset in the middle of a clear
      @(posedge clk); #1 bus.clear_req = 1'b1;
      for (int i = 0; i < 20; i++) push_wr(15'(i), 3'b000);
      @(posedge clk); #1 bus.clear_req = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("rclr_addr20", 32'(bus.ram_addr), 32'd20);
      rst = 1'b1;
      @(negedge clk);
      chk("rclr_wren", 32'(bus.ram_wren), 0);
      chk("rclr_busy", 32'(bus.busy), 0);
      chk("rclr_alive", 32'(bus.alive), 32'hF);
      chk("rclr_overrun", 32'(bus.overrun), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      chk("wq_drained", 32'(wq.size()), 0);
      chk("dq_drained", 32'(dq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
